// File: rtl/capture_buffer_initiator.sv
// capture_buffer_initiator
//   Drives capture_buffer's write and read channels for one I/Q burst.
//   A burst of BUFFER_LENGTH input samples is written to addresses
//   0..BUFFER_LENGTH-1. After the single write response is collected, the
//   same addresses are read back in order and the returned samples are
//   streamed out, one cycle per sample.
//
// Ports
//   clk, reset_n                      clock / asynchronous active-low reset
//   start                             begin a burst (honoured only when idle)
//   in_i, in_q, in_valid, in_ready    input sample stream
//   m_axi_waddr/wdata/wvalid,
//   s_axi_wready                      write address/data channel
//   s_axi_bresp/bvalid, m_axi_bready  write response channel
//   m_axi_raddr/rvalid/rready,
//   s_axi_rvalid, s_axi_i/q           read address / read data channel
//   out_i, out_q, out_valid           read-back sample stream (no backpressure)
//   busy, done, error                 status (error is sticky until next start)
module capture_buffer_initiator #(
  parameter int unsigned BUFFER_LENGTH = 32,
  parameter int unsigned INDEX_BITS    = 5,
  parameter int unsigned I_BITS        = 12,
  parameter int unsigned Q_BITS        = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [I_BITS-1:0]        in_i,
  input  logic [Q_BITS-1:0]        in_q,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [INDEX_BITS-1:0]    m_axi_waddr,
  output logic [I_BITS+Q_BITS-1:0] m_axi_wdata,
  output logic                     m_axi_wvalid,
  input  logic                     s_axi_wready,
  input  logic                     s_axi_bresp,
  input  logic                     s_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [INDEX_BITS-1:0]    m_axi_raddr,
  output logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  input  logic                     s_axi_rvalid,
  input  logic [I_BITS-1:0]        s_axi_i,
  input  logic [Q_BITS-1:0]        s_axi_q,
  output logic [I_BITS-1:0]        out_i,
  output logic [Q_BITS-1:0]        out_q,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  // One extra counter bit so a full count of 2**INDEX_BITS does not wrap.
  localparam int unsigned CNT_W = INDEX_BITS + 1;
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(BUFFER_LENGTH);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BUFFER_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_wcnt;   // completed write beats
  logic [CNT_W-1:0] r_acnt;   // samples accepted from the input stream
  logic [CNT_W-1:0] r_rcnt;   // read returns received

  logic             w_beat;
  logic             w_load;
  logic [CNT_W-1:0] w_wcnt_next;
  logic [CNT_W-1:0] w_acnt_next;
  logic [CNT_W-1:0] w_rcnt_next;

  // Single-entry skid: a new sample can be taken whenever the output
  // register is empty or is being drained this cycle. r_acnt stops intake
  // once the whole burst has been accepted, even if beats are still pending.
  always_comb begin
    in_ready = 1'b0;
    if (r_state == S_WRITE && r_acnt < LEN_C) begin
      in_ready = !m_axi_wvalid || s_axi_wready;
    end
  end

  assign w_beat      = m_axi_wvalid && s_axi_wready;
  assign w_load      = in_valid && in_ready;
  assign w_wcnt_next = r_wcnt + 1'b1;
  assign w_acnt_next = r_acnt + 1'b1;
  assign w_rcnt_next = r_rcnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_wcnt       <= '0;
      r_acnt       <= '0;
      r_rcnt       <= '0;
      m_axi_waddr  <= '0;
      m_axi_wdata  <= '0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
      m_axi_raddr  <= '0;
      m_axi_rvalid <= 1'b0;
      m_axi_rready <= 1'b0;
      out_i        <= '0;
      out_q        <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wcnt  <= '0;
            r_acnt  <= '0;
            r_rcnt  <= '0;
            error   <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_WRITE;
          end
        end

        S_WRITE: begin
          // Address follows the accept count: with back-to-back beats the
          // sample loaded alongside a completing beat belongs at wcnt+1.
          if (w_load) begin
            m_axi_wdata  <= {in_i, in_q};
            m_axi_waddr  <= r_acnt[INDEX_BITS-1:0];
            m_axi_wvalid <= 1'b1;
            r_acnt       <= w_acnt_next;
          end else if (w_beat) begin
            m_axi_wvalid <= 1'b0;
          end

          if (w_beat) begin
            r_wcnt <= w_wcnt_next;
            if (r_wcnt == LAST_C) begin
              m_axi_wvalid <= 1'b0;
              m_axi_bready <= 1'b1;
              r_state      <= S_WRESP;
            end
          end
        end

        S_WRESP: begin
          if (s_axi_bvalid) begin
            error        <= error | s_axi_bresp;
            m_axi_bready <= 1'b0;
            m_axi_raddr  <= '0;
            m_axi_rvalid <= 1'b1;
            m_axi_rready <= 1'b1;
            r_state      <= S_READ;
          end
        end

        S_READ: begin
          if (s_axi_rvalid) begin
            out_i     <= s_axi_i;
            out_q     <= s_axi_q;
            out_valid <= 1'b1;
            r_rcnt    <= w_rcnt_next;
            if (r_rcnt == LAST_C) begin
              // Address is left on the final location rather than wrapping.
              m_axi_rvalid <= 1'b0;
              m_axi_rready <= 1'b0;
              done         <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              m_axi_raddr <= w_rcnt_next[INDEX_BITS-1:0];
            end
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_buffer_initiator.sv
module tb_capture_buffer_initiator;

  localparam int LEN = 32;
  localparam int IB  = 5;
  localparam int IW  = 12;
  localparam int QW  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              start;
  logic [IW-1:0]     in_i;
  logic [QW-1:0]     in_q;
  logic              in_valid;
  logic              in_ready;
  logic [IB-1:0]     m_axi_waddr;
  logic [IW+QW-1:0]  m_axi_wdata;
  logic              m_axi_wvalid;
  logic              s_axi_wready;
  logic              s_axi_bresp;
  logic              s_axi_bvalid;
  logic              m_axi_bready;
  logic [IB-1:0]     m_axi_raddr;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic              s_axi_rvalid;
  logic [IW-1:0]     s_axi_i;
  logic [QW-1:0]     s_axi_q;
  logic [IW-1:0]     out_i;
  logic [QW-1:0]     out_q;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              error;

  capture_buffer_initiator #(
    .BUFFER_LENGTH(LEN),
    .INDEX_BITS   (IB),
    .I_BITS       (IW),
    .Q_BITS       (QW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .in_i        (in_i),
    .in_q        (in_q),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .m_axi_waddr (m_axi_waddr),
    .m_axi_wdata (m_axi_wdata),
    .m_axi_wvalid(m_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp (s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_raddr (m_axi_raddr),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_i     (s_axi_i),
    .s_axi_q     (s_axi_q),
    .out_i       (out_i),
    .out_q       (out_q),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bench-side capture buffer model
  logic [IW-1:0] exp_i [LEN];
  logic [QW-1:0] exp_q [LEN];
  logic [IW-1:0] mem_i [LEN];
  logic [QW-1:0] mem_q [LEN];
  logic          bresp_val;
  logic          rd_force;
  logic          wr_toggle;
  logic          exp_err;

  assign s_axi_bvalid = 1'b1;
  assign s_axi_bresp  = bresp_val;
  assign s_axi_rvalid = rd_force | m_axi_rvalid;
  assign s_axi_i      = mem_i[m_axi_raddr];
  assign s_axi_q      = mem_q[m_axi_raddr];

  always @(posedge clk) begin
    if (m_axi_wvalid && s_axi_wready) begin
      mem_i[m_axi_waddr] <= m_axi_wdata[IW+QW-1:QW];
      mem_q[m_axi_waddr] <= m_axi_wdata[QW-1:0];
    end
  end

  initial begin
    s_axi_wready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (wr_toggle) s_axi_wready = ~s_axi_wready;
      else           s_axi_wready = 1'b1;
    end
  end

  // Monitor state
  int            widx, ridx, rd_idx, done_cnt, wlow, hold_cnt;
  bit            have_hold = 1'b0;
  logic [IB-1:0] hold_addr;
  logic [23:0]   hold_data;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (have_hold && m_axi_wvalid) begin
          check("w_hold_addr", 64'(m_axi_waddr), 64'(hold_addr));
          check("w_hold_data", 64'(m_axi_wdata), 64'(hold_data));
          hold_cnt++;
        end
        have_hold = m_axi_wvalid && !s_axi_wready;
        hold_addr = m_axi_waddr;
        hold_data = m_axi_wdata;
        if (m_axi_wvalid && s_axi_wready) begin
          if (widx < LEN) begin
            check("w_addr", 64'(m_axi_waddr), 64'(widx));
            check("w_data", 64'(m_axi_wdata), 64'({exp_i[widx], exp_q[widx]}));
          end else begin
            check("w_extra_beat", 64'(1), 64'(0));
          end
          widx++;
        end
        if (busy && !m_axi_wvalid && widx > 0 && widx < LEN) wlow++;
        if (m_axi_rvalid && s_axi_rvalid) begin
          check("r_addr", 64'(m_axi_raddr), 64'(rd_idx));
          rd_idx++;
        end
        if (out_valid) begin
          if (ridx < LEN) begin
            check("out_i", 64'(out_i), 64'(exp_i[ridx]));
            check("out_q", 64'(out_q), 64'(exp_q[ridx]));
          end else begin
            check("out_extra", 64'(1), 64'(0));
          end
          ridx++;
        end
        if (done) begin
          done_cnt++;
          check("err_at_done", 64'(error), 64'(exp_err));
        end
      end else begin
        have_hold = 1'b0;
      end
    end
  end

  task automatic clear_model();
    widx = 0; ridx = 0; rd_idx = 0; done_cnt = 0; wlow = 0; hold_cnt = 0;
  endtask

  task automatic set_pattern(input int mode);
    for (int k = 0; k < LEN; k++) begin
      case (mode)
        0: begin exp_i[k] = 12'(k); exp_q[k] = 12'(-k); end
        1: begin
             exp_i[k] = (k % 2 == 1) ? 12'(2048 + k) : 12'(2047 - k);
             exp_q[k] = 12'(k * 129 - 2048);
           end
        default: begin exp_i[k] = 12'(-(k + 1) * 50); exp_q[k] = 12'(k * 100 - 1500); end
      endcase
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int n, input int gap);
    bit acc;
    int to;
    for (int k = 0; k < n; k++) begin
      in_i = exp_i[k];
      in_q = exp_q[k];
      in_valid = 1'b1;
      acc = 1'b0;
      to = 0;
      while (!acc && to < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        to++;
      end
      in_valid = 1'b0;
      if (!acc) begin
        check("in_accept_timeout", 64'(0), 64'(1));
        return;
      end
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_done();
    int to = 0;
    while (done_cnt == 0 && to < 600) begin
      @(negedge clk);
      to++;
    end
    check("done_seen", 64'(done_cnt != 0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt), 64'(1));
    check("beats_32", 64'(widx), 64'(LEN));
    check("reads_32", 64'(rd_idx), 64'(LEN));
    check("outs_32", 64'(ridx), 64'(LEN));
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int to;
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_i = '0; in_q = '0;
    bresp_val = 1'b0; rd_force = 1'b0; wr_toggle = 1'b0; exp_err = 1'b0;
    for (int k = 0; k < LEN; k++) begin mem_i[k] = '0; mem_q[k] = '0; end
    clear_model();
    set_pattern(0);

    #3;
    check("rst_ctrl", 64'({in_ready, m_axi_wvalid, m_axi_waddr, m_axi_bready, m_axi_raddr,
                           m_axi_rvalid, m_axi_rready, out_valid, busy, done, error}), 64'(0));
    check("rst_data", 64'({m_axi_wdata, out_i, out_q}), 64'(0));
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of the write phase
    pulse_start();
    send(5, 0);
    check("mid_busy", 64'(busy), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 64'({in_ready, m_axi_wvalid, m_axi_waddr, m_axi_bready, m_axi_raddr,
                               m_axi_rvalid, m_axi_rready, out_valid, busy, done, error}), 64'(0));
    check("mid_rst_data", 64'({m_axi_wdata, out_i, out_q}), 64'(0));
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_inrdy", 64'(in_ready), 64'(0));

    // Read data presented while idle must not produce output
    rd_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rvalid_idle_ignored", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    rd_force = 1'b0;

    // Full burst, continuous flow, in = (k, -k)
    clear_model();
    set_pattern(0);
    pulse_start();
    send(LEN, 0);
    wait_done();
    check("full_no_wgap", 64'(wlow), 64'(0));
    check("full_err", 64'(error), 64'(0));

    // Write backpressure: wready toggles every cycle
    clear_model();
    set_pattern(1);
    wr_toggle = 1'b1;
    pulse_start();
    send(LEN, 0);
    wait_done();
    wr_toggle = 1'b0;
    check("bp_stalls_seen", 64'(hold_cnt > 0), 64'(1));

    // Error response
    clear_model();
    set_pattern(2);
    bresp_val = 1'b1;
    exp_err = 1'b1;
    pulse_start();
    send(LEN, 0);
    wait_done();
    check("err_sticky_idle", 64'(error), 64'(1));
    bresp_val = 1'b0;

    // Next start clears error; start during READ is ignored
    clear_model();
    set_pattern(1);
    exp_err = 1'b0;
    pulse_start();
    check("err_cleared", 64'(error), 64'(0));
    check("start_busy", 64'(busy), 64'(1));
    send(LEN, 0);
    to = 0;
    while (!m_axi_rvalid && to < 100) begin
      @(negedge clk);
      to++;
    end
    check("read_phase_seen", 64'(m_axi_rvalid), 64'(1));
    pulse_start();
    wait_done();
    check("raddr_final", 64'(m_axi_raddr), 64'(LEN - 1));
    repeat (3) @(posedge clk);
    #1;
    check("no_restart", 64'(busy), 64'(0));

    // Input gaps of 3 cycles between samples
    clear_model();
    set_pattern(2);
    pulse_start();
    send(LEN, 3);
    wait_done();
    check("gap_wvalid_low", 64'(wlow >= LEN - 1), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
